register_counter_bank: RTL and testbench

REGISTER_COUNTER_BANK -- requirements
Module: register_counter_bank

---
 rtl/register_pkg.sv | 23 ++
 rtl/register_cell.sv | 56 +++++
 rtl/register_counter_bank.sv | 93 +++++++++
 tb/tb_register_counter_bank.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - shared count-op encoding and clog2 helper for the register counter bank
package register_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } count_op_e;

  // Ceiling log2, usable in constant (parameter) contexts; returns at least 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_cell.sv
// rtl/register_cell.sv - one loadable up/down counter register with wrap detect
module register_cell
  import register_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  count_op_e        op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_VALUE);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Load takes priority over counting; wrap only reported for a count that actually applies.
  always_comb begin
    value_d = value_q;
    wrap    = 1'b0;
    if (load) begin
      value_d = data;
    end else begin
      case (op)
        OP_INC: begin
          value_d = value_q + WIDTH'(1);
          wrap    = &value_q;
        end
        OP_DEC: begin
          value_d = value_q - WIDTH'(1);
          wrap    = ~|value_q;
        end
        default: begin
          value_d = value_q;
        end
      endcase
    end
  end

  // Register storage with synchronous reset to the default value.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RST_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/register_counter_bank.sv
// rtl/register_counter_bank.sv - bank of loadable counters with bus read port and shared carry flag
module register_counter_bank
  import register_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_REGS      = 4,
  parameter int DEFAULT_VALUE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic                       load_bus,
  input  logic [clog2(NUM_REGS)-1:0] load_sel,
  input  logic                       assert_bus,
  input  logic [clog2(NUM_REGS)-1:0] assert_sel,
  input  logic                       inc_n,
  input  logic                       dec_n,
  input  logic [clog2(NUM_REGS)-1:0] cnt_sel,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_en,
  output logic                       carry,
  output logic                       zero
);

  localparam int SEL_W = clog2(NUM_REGS);

  count_op_e            count_op;
  logic                 load_active;
  logic                 count_eff;
  logic [WIDTH-1:0]     cell_value [NUM_REGS];
  logic [NUM_REGS-1:0]  cell_wrap;
  logic                 carry_q;
  logic                 carry_d;

  assign load_active = ~load_bus;

  // Decode the strobes; both asserted together cancels out to no count.
  always_comb begin
    count_op = OP_NONE;
    if (!inc_n && dec_n) begin
      count_op = OP_INC;
    end else if (inc_n && !dec_n) begin
      count_op = OP_DEC;
    end
  end

  // A count is lost when a load hits the same register in the same cycle.
  assign count_eff = (count_op != OP_NONE) && !(load_active && (load_sel == cnt_sel));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    logic      cell_load;
    count_op_e cell_op;

    assign cell_load = load_active && (load_sel == SEL_W'(i));
    assign cell_op   = (cnt_sel == SEL_W'(i)) ? count_op : OP_NONE;

    register_cell #(
      .WIDTH        (WIDTH),
      .DEFAULT_VALUE(DEFAULT_VALUE)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .load (cell_load),
      .op   (cell_op),
      .data (bus_in),
      .value(cell_value[i]),
      .wrap (cell_wrap[i])
    );
  end

  // Carry follows the wrap of each effective count and holds otherwise.
  always_comb begin
    carry_d = carry_q;
    if (count_eff) begin
      carry_d = cell_wrap[cnt_sel];
    end
  end

  // Carry flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign carry   = carry_q;
  assign bus_out = cell_value[assert_sel];
  assign bus_en  = ~assert_bus;
  assign zero    = (cell_value[cnt_sel] == '0);

endmodule

// File: tb/tb_register_counter_bank.sv
// tb/tb_register_counter_bank.sv - table-driven self-checking bench for register_counter_bank
module tb_register_counter_bank;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       load_bus;
  logic [1:0] load_sel;
  logic       assert_bus;
  logic [1:0] assert_sel;
  logic       inc_n;
  logic       dec_n;
  logic [1:0] cnt_sel;
  logic [7:0] bus_out;
  logic       bus_en;
  logic       carry;
  logic       zero;

  int tests_run;
  int tests_failed;

  register_counter_bank #(
    .WIDTH        (8),
    .NUM_REGS     (4),
    .DEFAULT_VALUE(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .load_bus  (load_bus),
    .load_sel  (load_sel),
    .assert_bus(assert_bus),
    .assert_sel(assert_sel),
    .inc_n     (inc_n),
    .dec_n     (dec_n),
    .cnt_sel   (cnt_sel),
    .bus_out   (bus_out),
    .bus_en    (bus_en),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld_n;
    logic [1:0] ld_sel;
    logic [7:0] din;
    logic       ab;
    logic [1:0] asel;
    logic       inc_n;
    logic       dec_n;
    logic [1:0] csel;
    logic [7:0] e_out;
    logic       e_en;
    logic       e_carry;
    logic       e_zero;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic ldn, input logic [1:0] lsel,
                              input logic [7:0] d, input logic ab, input logic [1:0] asel,
                              input logic in, input logic dn, input logic [1:0] cs,
                              input logic [7:0] eo, input logic ee, input logic ec,
                              input logic ez);
    vec_t v;
    v.rst = r; v.ld_n = ldn; v.ld_sel = lsel; v.din = d; v.ab = ab; v.asel = asel;
    v.inc_n = in; v.dec_n = dn; v.csel = cs;
    v.e_out = eo; v.e_en = ee; v.e_carry = ec; v.e_zero = ez;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst        = v.rst;
    load_bus   = v.ld_n;
    load_sel   = v.ld_sel;
    bus_in     = v.din;
    assert_bus = v.ab;
    assert_sel = v.asel;
    inc_n      = v.inc_n;
    dec_n      = v.dec_n;
    cnt_sel    = v.csel;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; bus_in = 8'h00; load_bus = 1'b1; load_sel = 2'd0;
    assert_bus = 1'b1; assert_sel = 2'd0; inc_n = 1'b1; dec_n = 1'b1; cnt_sel = 2'd0;

    //            rst ldn lsel din    ab asel inc dec csel  out    en carry zero
    vecs[0]  = mk(1, 1, 2'd0, 8'h00, 0, 2'd0, 1, 1, 2'd0, 8'h00, 1, 0, 1);
    vecs[1]  = mk(0, 1, 2'd0, 8'h00, 0, 2'd1, 1, 1, 2'd1, 8'h00, 1, 0, 1);
    vecs[2]  = mk(0, 1, 2'd0, 8'h00, 0, 2'd2, 1, 1, 2'd2, 8'h00, 1, 0, 1);
    vecs[3]  = mk(0, 1, 2'd0, 8'h00, 0, 2'd3, 1, 1, 2'd3, 8'h00, 1, 0, 1);
    vecs[4]  = mk(0, 0, 2'd2, 8'hFF, 1, 2'd2, 1, 1, 2'd2, 8'hFF, 0, 0, 0);
    vecs[5]  = mk(0, 1, 2'd0, 8'h00, 1, 2'd2, 0, 1, 2'd2, 8'h00, 0, 1, 1);
    vecs[6]  = mk(0, 0, 2'd3, 8'h10, 0, 2'd3, 0, 1, 2'd3, 8'h10, 1, 1, 0);
    vecs[7]  = mk(0, 0, 2'd3, 8'h10, 0, 2'd3, 0, 1, 2'd0, 8'h10, 1, 0, 0);
    vecs[8]  = mk(0, 1, 2'd0, 8'h00, 0, 2'd0, 1, 1, 2'd0, 8'h01, 1, 0, 0);
    vecs[9]  = mk(0, 1, 2'd0, 8'h00, 0, 2'd1, 1, 0, 2'd1, 8'hFF, 1, 1, 0);
    vecs[10] = mk(0, 1, 2'd0, 8'h00, 0, 2'd1, 1, 0, 2'd1, 8'hFE, 1, 0, 0);
    vecs[11] = mk(0, 1, 2'd0, 8'h00, 0, 2'd1, 0, 1, 2'd1, 8'hFF, 1, 0, 0);
    vecs[12] = mk(0, 1, 2'd0, 8'h00, 0, 2'd1, 0, 1, 2'd1, 8'h00, 1, 1, 1);
    vecs[13] = mk(0, 1, 2'd0, 8'h00, 0, 2'd1, 0, 0, 2'd1, 8'h00, 1, 1, 1);
    vecs[14] = mk(0, 0, 2'd0, 8'h05, 0, 2'd0, 1, 1, 2'd0, 8'h05, 1, 1, 0);
    vecs[15] = mk(0, 1, 2'd0, 8'h00, 0, 2'd0, 0, 0, 2'd0, 8'h05, 1, 1, 0);
    vecs[16] = mk(0, 0, 2'd0, 8'h42, 0, 2'd0, 1, 1, 2'd0, 8'h42, 1, 1, 0);
    vecs[17] = mk(1, 0, 2'd0, 8'h99, 0, 2'd0, 0, 1, 2'd0, 8'h00, 1, 0, 1);
    vecs[18] = mk(0, 1, 2'd0, 8'h00, 0, 2'd3, 1, 1, 2'd3, 8'h00, 1, 0, 1);
    vecs[19] = mk(0, 1, 2'd0, 8'h00, 0, 2'd0, 1, 0, 2'd0, 8'hFF, 1, 1, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d bus_out", i), 32'(bus_out), 32'(vecs[i].e_out));
      check($sformatf("v%0d bus_en", i),  32'(bus_en),  32'(vecs[i].e_en));
      check($sformatf("v%0d carry", i),   32'(carry),   32'(vecs[i].e_carry));
      check($sformatf("v%0d zero", i),    32'(zero),    32'(vecs[i].e_zero));
    end

    // Read during write: reg0 holds FF, carry is 1; load 77 into reg0.
    @(negedge clk);
    rst = 1'b0; inc_n = 1'b1; dec_n = 1'b1; assert_sel = 2'd0; cnt_sel = 2'd0;
    load_bus = 1'b0; load_sel = 2'd0; bus_in = 8'h77; assert_bus = 1'b0;
    #1;
    check("rdw pre-edge bus_out", 32'(bus_out), 32'h0000_00FF);
    check("rdw pre-edge bus_en", 32'(bus_en), 32'd1);
    @(posedge clk);
    #1;
    check("rdw post-edge bus_out", 32'(bus_out), 32'h0000_0077);
    check("load-only carry hold", 32'(carry), 32'd1);

    // bus_en follows assert_bus combinationally, independent of rst.
    @(negedge clk);
    load_bus = 1'b1; assert_bus = 1'b1;
    #1;
    check("bus_en deassert", 32'(bus_en), 32'd0);
    rst = 1'b1; assert_bus = 1'b0;
    #1;
    check("bus_en under rst", 32'(bus_en), 32'd1);
    check("pre-reset bus_out", 32'(bus_out), 32'h0000_0077);
    @(posedge clk);
    #1;
    check("reset bus_out", 32'(bus_out), 32'h0000_0000);
    check("reset carry", 32'(carry), 32'd0);

    // First post-reset increment acts on the default value.
    @(negedge clk);
    rst = 1'b0; inc_n = 1'b0; cnt_sel = 2'd0;
    @(posedge clk);
    #1;
    check("post-reset inc", 32'(bus_out), 32'h0000_0001);
    check("post-reset carry", 32'(carry), 32'd0);
    @(negedge clk);
    inc_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
